// File: rtl/decoder_n_scan.sv
// rtl/decoder_n_scan.sv - N-to-2**N registered decoder with direct and auto-scanning modes
module decoder_n_scan #(
  parameter int N        = 2,
  parameter int SCAN_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              mode,
  input  logic              load,
  input  logic [N-1:0]      Input,
  output logic [2**N-1:0]   Output,
  output logic [N-1:0]      index,
  output logic              wrap
);

  localparam int W  = 2**N;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [PW-1:0] P_LAST   = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] P_ONE    = PW'(1);
  localparam logic [N-1:0]  IDX_ONE  = N'(1);
  localparam logic [N-1:0]  IDX_LAST = N'(W - 1);
  localparam logic [W-1:0]  OH_ONE   = W'(1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DIRECT = 2'd1;
  localparam logic [1:0] SCAN   = 2'd2;

  logic [1:0]    state;
  logic [1:0]    next_state;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_eff;
  logic          step;
  logic [N-1:0]  next_index;

  always_comb begin
    next_state = IDLE;
    if (enable) begin
      next_state = mode ? SCAN : DIRECT;
    end
  end

  // Entering SCAN counts the entry cycle as prescaler 0, so the first step lands SCAN_DIV edges later.
  always_comb begin
    presc_eff = (state == SCAN) ? presc : '0;
    step      = (next_state == SCAN) && !load && (presc_eff == P_LAST);
  end

  always_comb begin
    next_index = index;
    case (next_state)
      DIRECT: next_index = Input;
      SCAN: begin
        if (load) begin
          next_index = Input;
        end else if (step) begin
          next_index = index + IDX_ONE;
        end
      end
      default: next_index = index;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      index  <= '0;
      presc  <= '0;
      Output <= '0;
      wrap   <= 1'b0;
    end else begin
      state <= next_state;
      index <= next_index;
      case (next_state)
        DIRECT: begin
          Output <= OH_ONE << Input;
          presc  <= '0;
          wrap   <= 1'b0;
        end
        SCAN: begin
          Output <= OH_ONE << next_index;
          wrap   <= step && (index == IDX_LAST);
          presc  <= (load || step) ? '0 : presc_eff + P_ONE;
        end
        default: begin
          Output <= '0;
          wrap   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_n_scan.sv
// tb/tb_decoder_n_scan.sv - directed bench for decoder_n_scan (N=2/SCAN_DIV=4 and N=3/SCAN_DIV=1)
module tb_decoder_n_scan;

  logic       clk;
  logic       rst1, en1, mode1, load1;
  logic [1:0] in1;
  logic [3:0] out1;
  logic [1:0] idx1;
  logic       wrap1;

  logic       rst2, en2, mode2, load2;
  logic [2:0] in2;
  logic [7:0] out2;
  logic [2:0] idx2;
  logic       wrap2;

  int tests;
  int fails;

  decoder_n_scan #(.N(2), .SCAN_DIV(4)) dut1 (
    .clk(clk), .reset(rst1), .enable(en1), .mode(mode1), .load(load1),
    .Input(in1), .Output(out1), .index(idx1), .wrap(wrap1)
  );

  decoder_n_scan #(.N(3), .SCAN_DIV(1)) dut2 (
    .clk(clk), .reset(rst2), .enable(en2), .mode(mode2), .load(load2),
    .Input(in2), .Output(out2), .index(idx2), .wrap(wrap2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic [3:0] o, input logic [1:0] i, input logic w);
    check({tag, ".out"},  {28'd0, out1}, {28'd0, o});
    check({tag, ".idx"},  {30'd0, idx1}, {30'd0, i});
    check({tag, ".wrap"}, {31'd0, wrap1}, {31'd0, w});
  endtask

  initial begin
    logic [3:0] exp_o;
    logic [7:0] exp_o8;
    logic [1:0] exp_i;
    logic [2:0] exp_i8;
    tests = 0;
    fails = 0;
    rst1 = 1'b1; en1 = 1'b0; mode1 = 1'b0; load1 = 1'b0; in1 = 2'd0;
    rst2 = 1'b1; en2 = 1'b0; mode2 = 1'b0; load2 = 1'b0; in2 = 3'd0;
    #2;
    check1("reset", 4'b0000, 2'd0, 1'b0);
    tick();
    rst1 = 1'b0;

    // DIRECT decode, one-cycle latency
    en1 = 1'b1; mode1 = 1'b0; in1 = 2'd2;
    tick();
    check1("direct2", 4'b0100, 2'd2, 1'b0);
    in1 = 2'd3; load1 = 1'b1;
    tick();
    check1("direct3_load_ignored", 4'b1000, 2'd3, 1'b0);
    load1 = 1'b0; in1 = 2'd0;
    tick();
    check1("direct0", 4'b0001, 2'd0, 1'b0);

    // SCAN timing from reset
    #2 rst1 = 1'b1;
    #1 rst1 = 1'b0;
    mode1 = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_i = 2'((k / 4) % 4);
      exp_o = 4'b0001 << exp_i;
      check1($sformatf("scan_k%0d", k), exp_o, exp_i, (k == 16));
    end

    // load at index=1, prescaler=2
    for (int k = 0; k < 6; k++) tick();
    check1("pre_load", 4'b0010, 2'd1, 1'b0);
    load1 = 1'b1; in1 = 2'd3;
    tick();
    load1 = 1'b0;
    check1("load3", 4'b1000, 2'd3, 1'b0);
    for (int k = 0; k < 3; k++) tick();
    check1("after_load_hold", 4'b1000, 2'd3, 1'b0);
    tick();
    check1("after_load_wrap", 4'b0001, 2'd0, 1'b1);
    tick();
    check1("wrap_one_cycle", 4'b0001, 2'd0, 1'b0);

    // IDLE hold at index=2
    for (int k = 0; k < 8; k++) tick();
    check1("reach_idx2", 4'b0100, 2'd2, 1'b0);
    en1 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check1($sformatf("idle_k%0d", k), 4'b0000, 2'd2, 1'b0);
    end
    en1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check1($sformatf("resume_k%0d", k), 4'b0100, 2'd2, 1'b0);
    end
    tick();
    check1("resume_step", 4'b1000, 2'd3, 1'b0);

    // load 3 -> 0 never raises wrap
    load1 = 1'b1; in1 = 2'd0;
    tick();
    load1 = 1'b0;
    check1("load0_no_wrap", 4'b0001, 2'd0, 1'b0);

    // DIRECT then SCAN resumes from the last decoded index with a fresh prescaler
    mode1 = 1'b0; in1 = 2'd2;
    tick();
    check1("direct_before_scan", 4'b0100, 2'd2, 1'b0);
    mode1 = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    check1("scan_entry_hold", 4'b0100, 2'd2, 1'b0);
    tick();
    check1("scan_entry_step", 4'b1000, 2'd3, 1'b0);

    // asynchronous reset between edges
    load1 = 1'b1; in1 = 2'd1;
    tick();
    load1 = 1'b0;
    check1("pre_async", 4'b0010, 2'd1, 1'b0);
    #2 rst1 = 1'b1;
    #1;
    check1("async_reset", 4'b0000, 2'd0, 1'b0);
    tick();
    #2 rst1 = 1'b0;
    en1 = 1'b0;
    tick();
    check1("post_reset_idle", 4'b0000, 2'd0, 1'b0);

    // N=3, SCAN_DIV=1: a step every cycle
    rst2 = 1'b0; en2 = 1'b1; mode2 = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_i8 = 3'(k % 8);
      exp_o8 = 8'b0000_0001 << exp_i8;
      check($sformatf("div1_k%0d.out", k),  {24'd0, out2}, {24'd0, exp_o8});
      check($sformatf("div1_k%0d.idx", k),  {29'd0, idx2}, {29'd0, exp_i8});
      check($sformatf("div1_k%0d.wrap", k), {31'd0, wrap2}, {31'd0, (k % 8 == 0)});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decoder_n_scan.md
DECODER_N_SCAN -- requirements
Module: decoder_n_scan

Interface
REQ-001 SHALL have parameter N, default 2, meaning select width; Output width is 2**N; legal range 1..6.
REQ-002 SHALL have parameter SCAN_DIV, default 4, meaning clock cycles per scan step; legal range 1..65535.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  1 = decoder active; 0 = outputs forced to zero, state held.
REQ-006 SHALL have port mode  input  1  0 = DIRECT decode of Input; 1 = SCAN (auto-advancing one-hot).
REQ-007 SHALL have port load  input  1  in SCAN, loads Input into the scan index.
REQ-008 SHALL have port Input  input  N  binary select.
REQ-009 SHALL have port Output  output  2**N  registered one-hot or all-zero.
REQ-010 SHALL have port index  output  N  registered binary index currently decoded.
REQ-011 SHALL have port wrap  output  1  registered one-cycle pulse on scan wrap from 2**N-1 to 0.

Function
REQ-012 SHALL implement states IDLE, DIRECT, SCAN, evaluated each cycle: enable=0 -> IDLE; enable=1,mode=0 -> DIRECT; enable=1,mode=1 -> SCAN.
REQ-013 SHALL in IDLE drive Output=0 and wrap=0 from the next edge, with index and prescaler holding their values.
REQ-014 SHALL in DIRECT register index<=Input and Output<=one-hot(Input) (bit Input set), latency exactly 1 cycle.
REQ-015 SHALL in DIRECT hold prescaler at 0 and wrap at 0.
REQ-016 SHALL in SCAN run a prescaler counting 0..SCAN_DIV-1; at terminal count the prescaler returns to 0 and index increments modulo 2**N.
REQ-017 SHALL with SCAN_DIV=1 advance index every SCAN cycle.
REQ-018 SHALL in SCAN drive Output=one-hot(index) registered, so Output always reflects the index register value.
REQ-019 SHALL assert wrap for exactly one cycle, aligned with index becoming 0, only when stepping from 2**N-1; never on load.
REQ-020 SHALL in SCAN with load=1 set index<=Input and prescaler<=0, overriding any step in that cycle; wrap=0 that cycle.
REQ-021 SHALL ignore load in DIRECT and IDLE.
REQ-022 SHALL clear the prescaler on every transition into SCAN; scanning resumes from the held or last-decoded index.
REQ-023 SHALL, when leaving SCAN for IDLE and re-entering SCAN, resume from the held index with a freshly cleared prescaler.
REQ-024 SHALL keep Output strictly one-hot in DIRECT/SCAN and all-zero in IDLE; no glitch values are permitted at any register output.
REQ-025 SHALL size the prescaler to ceil(log2(SCAN_DIV)) bits (minimum 1) with no overflow past SCAN_DIV-1.

Reset
REQ-026 SHALL on reset=1, asynchronously and independent of clk, force Output=0, index=0, wrap=0, prescaler=0, state=IDLE.
REQ-027 SHALL on reset deassertion resume normal evaluation at the first subsequent rising edge; reset mid-scan discards index and prescaler.

Verification
REQ-028 SHALL cover DIRECT: N=2, enable=1, mode=0, Input=2'b10 -> Output=4'b0100, index=2 one cycle later; Input=3 -> 4'b1000.
REQ-029 SHALL cover SCAN timing: N=2, SCAN_DIV=4, from reset enable=1, mode=1 -> index steps 0,1,2,3,0 every 4 cycles; wrap=1 only the cycle index returns to 0.
REQ-030 SHALL cover load: in SCAN at index=1 with prescaler=2, load=1, Input=3 -> index=3, Output=4'b1000 next cycle, next step 4 cycles later to 0 with wrap=1.
REQ-031 SHALL cover IDLE hold: during SCAN at index=2, enable=0 for 10 cycles -> Output=0, index=2 held; enable=1 -> index=2, step after 4 cycles to 3.
REQ-032 SHALL cover async reset: reset pulsed between clock edges while Output=4'b0010 -> Output=0, index=0, wrap=0 immediately, without a clock edge.
REQ-033 SHALL cover SCAN_DIV=1, N=3: index steps every cycle 0..7, wrap pulses every 8 cycles, Output one-hot on all 8 bits.
